// File: rtl/ama_riscv_reg_file_mp_pkg.sv
// Shared register-file constants: ABI register names and the hard-wired zero address.
package ama_riscv_reg_file_mp_pkg;

  localparam int RF_ZERO = 0;

  typedef enum logic [4:0] {
    RF_X0_ZERO, RF_X1_RA,  RF_X2_SP,  RF_X3_GP,  RF_X4_TP,  RF_X5_T0,  RF_X6_T1,  RF_X7_T2,
    RF_X8_S0,   RF_X9_S1,  RF_X10_A0, RF_X11_A1, RF_X12_A2, RF_X13_A3, RF_X14_A4, RF_X15_A5,
    RF_X16_A6,  RF_X17_A7, RF_X18_S2, RF_X19_S3, RF_X20_S4, RF_X21_S5, RF_X22_S6, RF_X23_S7,
    RF_X24_S8,  RF_X25_S9, RF_X26_S10, RF_X27_S11, RF_X28_T3, RF_X29_T4, RF_X30_T5, RF_X31_T6
  } rf_abi_e;

  // ABI name narrowed to an AW-bit address; small files alias the upper names.
  function automatic int unsigned rf_abi_addr(rf_abi_e r, int aw);
    return int'(r) & ((1 << aw) - 1);
  endfunction

endpackage

// File: rtl/ama_riscv_rf_read_port.sv
// One register-file read port: address mux, writeback bypass compare and busy lookup.
module ama_riscv_rf_read_port
  import ama_riscv_reg_file_mp_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                       rst_n,
  input  logic [AW-1:0]              rd_addr,
  input  logic [NREG-1:0][XLEN-1:0]  regs,
  input  logic [NREG-1:0]            busy,
  input  logic                       we,
  input  logic [AW-1:0]              wr_addr,
  input  logic [XLEN-1:0]            wr_data,
  output logic [XLEN-1:0]            rd_data,
  output logic                       rd_busy
);

  localparam logic BYP = (BYPASS != 0);

  logic nz, hit;

  assign nz  = (rd_addr != AW'(RF_ZERO));
  assign hit = BYP && we && (wr_addr == rd_addr);

  // Gating by rst_n keeps the forwarding path quiet while storage is held in reset.
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (rst_n && nz) begin
      rd_data = hit ? wr_data : regs[rd_addr];
      rd_busy = !hit && busy[rd_addr];
    end
  end

endmodule

// File: rtl/ama_riscv_reg_file_mp.sv
// Multi-port integer register file with per-register write-pending scoreboard.
module ama_riscv_reg_file_mp
  import ama_riscv_reg_file_mp_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRP    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRP*AW-1:0]    rd_addr,
  output logic [NRP*XLEN-1:0]  rd_data,
  output logic [NRP-1:0]       rd_busy,
  input  logic                 we,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic                 sb_flush
);

  logic [XLEN-1:0]           regs_q [NREG-1:1];
  logic [NREG-1:1]           busy_q, busy_d;
  logic [NREG-1:0][XLEN-1:0] regs_all;
  logic [NREG-1:0]           busy_all;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NREG; r++) regs_q[r] <= '0;
    end else if (we && wr_addr != AW'(RF_ZERO)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Later assignments win: set (younger instr) over flush over writeback clear.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (we && wr_addr == AW'(r))      busy_d[r] = 1'b0;
      if (sb_flush)                     busy_d[r] = 1'b0;
      if (sb_set && sb_addr == AW'(r))  busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    regs_all[0] = '0;
    for (int r = 1; r < NREG; r++) regs_all[r] = regs_q[r];
  end

  assign busy_all = {busy_q, 1'b0};

  for (genvar i = 0; i < NRP; i++) begin : g_rp
    ama_riscv_rf_read_port #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .BYPASS (BYPASS)
    ) u_rp (
      .rst_n   (rst_n),
      .rd_addr (rd_addr[i*AW +: AW]),
      .regs    (regs_all),
      .busy    (busy_all),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[i*XLEN +: XLEN]),
      .rd_busy (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_ama_riscv_reg_file_mp.sv
// Directed checks on default/no-bypass instances plus random traffic on two swept configurations.
module tb_ama_riscv_reg_file_mp;

  logic clk, rst_n;

  // default config (shared inputs), BYPASS=1 and BYPASS=0
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        we, sb_set, sb_flush;
  logic [4:0]  wr_addr, sb_addr;
  logic [31:0] wr_data;

  // sweep A: XLEN=64 NREG=16 NRP=3
  logic [11:0]  a_rd_addr;
  logic [191:0] a_rd_data;
  logic [2:0]   a_rd_busy;
  logic         a_we, a_sb_set, a_sb_flush;
  logic [3:0]   a_wr_addr, a_sb_addr;
  logic [63:0]  a_wr_data;

  // sweep B: XLEN=32 NREG=32 NRP=4
  logic [19:0]  b_rd_addr;
  logic [127:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_we, b_sb_set, b_sb_flush;
  logic [4:0]   b_wr_addr, b_sb_addr;
  logic [31:0]  b_wr_data;

  int total = 0;
  int bad   = 0;

  logic [63:0] ma  [16];
  logic        mba [16];
  logic [31:0] mb  [32];
  logic        mbb [32];

  ama_riscv_reg_file_mp #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush));

  ama_riscv_reg_file_mp #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush));

  ama_riscv_reg_file_mp #(.XLEN(64), .NREG(16), .NRP(3), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .we(a_we), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .sb_set(a_sb_set), .sb_addr(a_sb_addr), .sb_flush(a_sb_flush));

  ama_riscv_reg_file_mp #(.XLEN(32), .NREG(32), .NRP(4), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .we(b_we), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .sb_set(b_sb_set), .sb_addr(b_sb_addr), .sb_flush(b_sb_flush));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we = 0; sb_set = 0; sb_flush = 0;
  endtask

  initial begin
    rst_n = 0; rd_addr = '0; we = 0; wr_addr = '0; wr_data = '0;
    sb_set = 0; sb_addr = '0; sb_flush = 0;
    a_rd_addr = '0; a_we = 0; a_wr_addr = '0; a_wr_data = '0; a_sb_set = 0; a_sb_addr = '0; a_sb_flush = 0;
    b_rd_addr = '0; b_we = 0; b_wr_addr = '0; b_wr_data = '0; b_sb_set = 0; b_sb_addr = '0; b_sb_flush = 0;

    // reset: bypass path gated too
    we = 1; wr_addr = 5; wr_data = 32'hABC; rd_addr = {5'd5, 5'd5};
    #1;
    chk("rst_data0", rd_data[31:0], 0);
    chk("rst_data1", rd_data[63:32], 0);
    chk("rst_busy", rd_busy, 0);
    step();
    chk("rst_hold_data", rd_data[31:0], 0);
    idle();
    #2 rst_n = 1;

    // write x5 and mark busy, then async reset mid-cycle
    we = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; sb_set = 1; sb_addr = 5; rd_addr = {5'd0, 5'd5};
    step();
    idle();
    #1;
    chk("x5_written", rd_data[31:0], 32'hDEADBEEF);
    chk("x5_busy", rd_busy[0], 1);
    #1 rst_n = 0;
    #1;
    chk("async_rst_data", rd_data[31:0], 0);
    chk("async_rst_busy", rd_busy[0], 0);
    #1 rst_n = 1;

    // reset held across a write edge drops the write
    we = 1; wr_addr = 6; wr_data = 32'h77; rd_addr = {5'd0, 5'd6};
    rst_n = 0;
    step();
    rst_n = 1; idle();
    #1;
    chk("rst_mid_write", rd_data[31:0], 0);

    // x0 is never written nor busy
    we = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; sb_set = 1; sb_addr = 0; rd_addr = {5'd0, 5'd0};
    #1;
    chk("x0_same_cyc", rd_data[31:0], 0);
    step();
    idle();
    #1;
    chk("x0_data", rd_data[31:0], 0);
    chk("x0_busy", rd_busy[0], 0);

    // bypass
    we = 1; wr_addr = 10; wr_data = 32'h1;
    step();
    idle(); rd_addr = {5'd10, 5'd10};
    #1;
    chk("x10_init", rd_data[31:0], 1);
    we = 1; wr_addr = 10; wr_data = 32'h1234;
    #1;
    chk("byp_p0", rd_data[31:0], 32'h1234);
    chk("byp_p1", rd_data[63:32], 32'h1234);
    chk("nobyp_p0", rd_data_nb[31:0], 32'h1);
    chk("nobyp_p1", rd_data_nb[63:32], 32'h1);
    step();
    idle();
    #1;
    chk("nobyp_next_p0", rd_data_nb[31:0], 32'h1234);
    chk("nobyp_next_p1", rd_data_nb[63:32], 32'h1234);

    // scoreboard set / writeback clear
    rd_addr = {5'd0, 5'd7}; sb_set = 1; sb_addr = 7;
    #1;
    chk("sb_pre_edge", rd_busy[0], 0);
    step();                                     // edge N
    idle();
    #1;
    chk("sb_n1", rd_busy[0], 1);
    chk("sb_n1_nb", rd_busy_nb[0], 1);
    step(); step();                             // N+1, N+2
    chk("sb_n3_hold", rd_busy[0], 1);
    we = 1; wr_addr = 7; wr_data = 32'h55;
    #1;
    chk("wb_busy_byp", rd_busy[0], 0);
    chk("wb_busy_nobyp", rd_busy_nb[0], 1);
    chk("wb_data_byp", rd_data[31:0], 32'h55);
    step();                                     // N+3
    idle();
    #1;
    chk("wb_cleared", rd_busy[0], 0);
    chk("wb_cleared_nb", rd_busy_nb[0], 0);
    chk("wb_data", rd_data_nb[31:0], 32'h55);

    // set vs writeback collision
    sb_set = 1; sb_addr = 7;
    step();
    idle();
    we = 1; wr_addr = 7; wr_data = 32'h99; sb_set = 1; sb_addr = 7;
    step();
    idle();
    #1;
    chk("coll_data", rd_data[31:0], 32'h99);
    chk("coll_busy", rd_busy[0], 1);
    chk("coll_busy_nb", rd_busy_nb[0], 1);

    // flush with simultaneous set
    we = 1; wr_addr = 3; wr_data = 32'h33; sb_set = 1; sb_addr = 3;
    step();
    idle(); sb_set = 1; sb_addr = 4;
    step();
    sb_addr = 31;
    step();
    idle(); sb_flush = 1; sb_set = 1; sb_addr = 9;
    step();
    idle(); rd_addr = {5'd9, 5'd3};
    #1;
    chk("fl_x3_busy", rd_busy[0], 0);
    chk("fl_x9_busy", rd_busy[1], 1);
    chk("fl_x3_data", rd_data[31:0], 32'h33);
    rd_addr = {5'd4, 5'd31};
    #1;
    chk("fl_x31_busy", rd_busy[0], 0);
    chk("fl_x4_busy", rd_busy[1], 0);
    rd_addr = {5'd10, 5'd7};
    #1;
    chk("fl_x7_busy", rd_busy[0], 0);
    chk("fl_x7_data", rd_data[31:0], 32'h99);
    chk("fl_x10_data", rd_data[63:32], 32'h1234);

    // sweep: fresh reset, random traffic against reference models
    rst_n = 0;
    for (int r = 0; r < 16; r++) begin ma[r] = '0; mba[r] = 0; end
    for (int r = 0; r < 32; r++) begin mb[r] = '0; mbb[r] = 0; end
    step();
    rst_n = 1;
    for (int c = 0; c < 300; c++) begin
      a_we = 1'($urandom_range(0, 1)); a_wr_addr = 4'($urandom_range(0, 15));
      a_wr_data = {$urandom, $urandom};
      a_sb_set = 1'($urandom_range(0, 1)); a_sb_addr = 4'($urandom_range(0, 15));
      a_sb_flush = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < 3; p++) a_rd_addr[p*4 +: 4] = 4'($urandom_range(0, 15));
      b_we = 1'($urandom_range(0, 1)); b_wr_addr = 5'($urandom_range(0, 31));
      b_wr_data = $urandom;
      b_sb_set = 1'($urandom_range(0, 1)); b_sb_addr = 5'($urandom_range(0, 31));
      b_sb_flush = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < 4; p++) b_rd_addr[p*5 +: 5] = 5'($urandom_range(0, 7) * 4 + $urandom_range(0, 1));
      #1;
      for (int p = 0; p < 3; p++) begin
        int ad;
        logic [63:0] ed;
        logic eb;
        ad = int'(a_rd_addr[p*4 +: 4]);
        ed = (ad == 0) ? 64'd0 : (a_we && int'(a_wr_addr) == ad) ? a_wr_data : ma[ad];
        eb = (ad != 0) && !(a_we && int'(a_wr_addr) == ad) && mba[ad];
        chk("swA_data", a_rd_data[p*64 +: 64], ed);
        chk("swA_busy", 64'(a_rd_busy[p]), 64'(eb));
      end
      for (int p = 0; p < 4; p++) begin
        int ad;
        logic [31:0] ed;
        logic eb;
        ad = int'(b_rd_addr[p*5 +: 5]);
        ed = (ad == 0) ? 32'd0 : (b_we && int'(b_wr_addr) == ad) ? b_wr_data : mb[ad];
        eb = (ad != 0) && !(b_we && int'(b_wr_addr) == ad) && mbb[ad];
        chk("swB_data", 64'(b_rd_data[p*32 +: 32]), 64'(ed));
        chk("swB_busy", 64'(b_rd_busy[p]), 64'(eb));
      end
      @(posedge clk);
      if (a_we && a_wr_addr != 0) begin ma[a_wr_addr] = a_wr_data; mba[a_wr_addr] = 0; end
      if (a_sb_flush) for (int r = 0; r < 16; r++) mba[r] = 0;
      if (a_sb_set && a_sb_addr != 0) mba[a_sb_addr] = 1;
      if (b_we && b_wr_addr != 0) begin mb[b_wr_addr] = b_wr_data; mbb[b_wr_addr] = 0; end
      if (b_sb_flush) for (int r = 0; r < 32; r++) mbb[r] = 0;
      if (b_sb_set && b_sb_addr != 0) mbb[b_sb_addr] = 1;
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ama_riscv_reg_file_mp.md
# ama_riscv_reg_file_mp

Parametrised multi-port integer register file with an integrated write-pending scoreboard, the successor to the fixed 32x32 two-read-port register file in the AMA-RISCV core. It sits between decode (read ports, scoreboard set) and writeback (write port). It adds the following over the fixed version:

- configurable data width, register count and read-port count;
- optional same-cycle write-to-read bypass;
- per-register busy tracking with flush, so decode can detect RAW hazards without an external scoreboard.

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `NREG`, 32, number of architectural registers; power of two, >= 2. Address width `AW = $clog2(NREG)`.
- `NRP`, 2, number of read ports; 1..4.
- `BYPASS`, 1, 1 = same-cycle writeback forwarding to read ports and busy outputs; 0 = no forwarding.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rd_addr`  in  NRP*AW  read addresses; port i is bits `[i*AW +: AW]`.
- `rd_data`  out  NRP*XLEN  read data for port i; combinational.
- `rd_busy`  out  NRP  port i's register has a pending write; combinational.
- `we`  in  1  writeback enable.
- `wr_addr`  in  AW  writeback address.
- `wr_data`  in  XLEN  writeback data.
- `sb_set`  in  1  issue of an instruction with a destination register; marks it busy.
- `sb_addr`  in  AW  destination register being marked.
- `sb_flush`  in  1  pipeline flush; clears all busy bits.

## Operation
- Register 0 is hard-wired zero:
  - writes to address 0 are ignored;
  - reads of address 0 return 0;
  - register 0 is never busy (`sb_set` with `sb_addr`=0 is ignored).
- Storage: `NREG-1` registers of `XLEN` bits. Busy vector `busy_q[NREG-1:1]`.
- Write: on a rising edge with `we`=1 and `wr_addr`!=0, `reg[wr_addr] <= wr_data`.
- Read port i:
  - `rd_addr_i`=0 -> 0;
  - else if `BYPASS`=1 and `we`=1 and `wr_addr`==`rd_addr_i` -> `wr_data`;
  - else `reg[rd_addr_i]`.
- Busy port i:
  - `rd_busy[i] = busy_q[rd_addr_i]`;
  - when `BYPASS`=1, forced to 0 if `we`=1 and `wr_addr`==`rd_addr_i`;
  - always 0 for address 0.
- Scoreboard next state, per register r, in priority order (highest first):
  1. `sb_set` and `sb_addr`==r -> 1. Set wins over same-cycle writeback and flush, because it is the younger instruction.
  2. `sb_flush` -> 0.
  3. `we` and `wr_addr`==r -> 0.
  4. Otherwise hold.
- A writeback to a non-busy register is legal. It updates data and leaves busy at 0.
- Simultaneous writeback and reads of the same address on all NRP ports all see the same forwarded value.

## Timing
- Reset: while `rst_n`=0:
  - all registers and `busy_q` clear to 0 asynchronously;
  - `rd_data` reads 0 on all ports and `rd_busy`=0, including the bypass path, which is gated by `rst_n`.
- Reset asserted mid-write: the write is dropped and the register reads 0 after reset.
- Reset deassertion is synchronised externally. The first write is accepted on the first rising edge with `rst_n`=1.
- Write latency: data visible on `rd_data` one cycle after the writeback edge, or in the same cycle combinationally with `BYPASS`=1.
- Scoreboard latency: `sb_set` at edge N -> `rd_busy`=1 from N+1. `sb_flush` at edge N -> all busy 0 from N+1.
- No handshakes; every input is sampled on every edge. Read ports have no cycle latency.

## Structure
- `ama_riscv_defines.v`:
  - gets the ABI register address macros generalised to `AW`-bit values;
  - gets the `RF_ZERO` address constant;
  - the existing `RF_X*` names remain valid.
- Sub-module `ama_riscv_rf_read_port`:
  - a single read mux plus bypass compare plus busy lookup;
  - parameters `XLEN`, `NREG`, `BYPASS`;
  - instantiated `NRP` times in a generate loop.
- Storage and scoreboard registers live in the top module in one async-reset always block each.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse `rst_n` low mid-cycle -> x5 reads 0 and `rd_busy`=0 immediately, without waiting for a clock edge.
- x0: `we`=1, `wr_addr`=0, `wr_data`=0xFFFFFFFF and `sb_set` `sb_addr`=0 -> port 0 reads 0 and `rd_busy[0]`=0 on the next cycle.
- Bypass (`BYPASS`=1): x10 holds 0x1. Writeback x10=0x1234 with ports 0 and 1 both addressing x10 -> both read 0x1234 in the same cycle. With `BYPASS`=0 -> both read 0x1 that cycle and 0x1234 the next.
- Scoreboard: `sb_set` x7 at edge N -> `rd_busy`=1 at N+1. Writeback x7=0x55 at edge N+3 -> `rd_busy`=0 combinationally in cycle N+3 (`BYPASS`=1), and busy cleared from N+4.
- Set vs clear collision: x7 busy, then writeback x7 and `sb_set` x7 on the same edge -> x7 holds the written data and stays busy.
- Flush: set x3, x4 and x31, then `sb_flush` together with `sb_set` x9 -> after the edge only x9 is busy; register contents are unchanged.
- Parameter sweep: run the sweep for each of these configurations, each with random write/read traffic checked against a reference model:
  - `XLEN`=64, `NREG`=16, `NRP`=3;
  - `XLEN`=32, `NREG`=32, `NRP`=4.
